serial_bank_link: RTL and testbench

Parametrised serial link endpoint that moves a whole register bank across a two-wire (sen/sd) half-duplex link, one framed word per bank address. In transmit mode it reads the bank and serialises tagged, parity-protected frames. In receive mode it deserialises frames, checks them, and writes good words back into the bank. It replaces the fixed 18-bit / 8-entry sender-receiver, adding frame tags, even parity, length checking and an error counter.

---
 rtl/serial_bank_link_if.sv | 16 +
 rtl/serial_bank_link.sv | 153 +++++++++++++++
 tb/tb_serial_bank_link.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_bank_link_if.sv
// Bank-side bus of serial_bank_link: address, write data, read data, read/write strobe.
// Ports: bank_a (address), bank_d (write data), bank_q (read data, combinational from bank_a),
//        rw (1 = read, 0 = write on the clk edge while low).
interface serial_bank_link_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] bank_a;
  logic [DATA_W-1:0] bank_d;
  logic [DATA_W-1:0] bank_q;
  logic              rw;

  // Link endpoint drives the bank; the bank returns read data.
  modport master (output bank_a, output bank_d, output rw, input bank_q);
  modport slave  (input bank_a, input bank_d, input rw, output bank_q);
endinterface

// File: rtl/serial_bank_link.sv
// Half-duplex serial endpoint that sends (updown=1) or receives (updown=0) a whole register bank
// as tagged, even-parity frames {tag, addr, data, p}, MSB first, framed by active-low sen.
// Ports: clk/rst (async, active-high); updown mode; bank bus via serial_bank_link_if.master;
//        done (sticky), par_err (reject pulse), err_cnt (saturating), sen/sd (tri-stated in RX).
module serial_bank_link #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 3,
  parameter int TAG_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               updown,
  serial_bank_link_if.master bank,
  output logic               done,
  output logic               par_err,
  output logic [7:0]         err_cnt,
  inout  wire                sen,
  inout  wire                sd
);
  localparam int L  = TAG_W + ADDR_W + DATA_W + 1;
  localparam int N  = 1 << ADDR_W;
  localparam int CW = $clog2(L + 2);
  localparam int GW = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, DONE} state_t;

  state_t            state, nxt;
  logic              updown_q;
  logic [ADDR_W-1:0] k;
  logic [TAG_W-1:0]  tx_tag;
  logic [CW-1:0]     bcnt;      // TX: shift position; RX: received bits, saturating at L+1
  logic [L-1:0]      sr;        // shared shift register, TX and RX never active together
  logic [GW-1:0]     good_cnt;
  logic [TAG_W-1:0]  rx_tag;    // tag expected on the next good frame
  logic              rx_we;
  logic [ADDR_W-1:0] rx_a;
  logic [DATA_W-1:0] rx_d;
  logic              sen_drv, sd_drv;
  logic              mode_chg, tx_par, rx_good;

  assign mode_chg = (updown != updown_q);
  assign tx_par   = ^{tx_tag, k, bank.bank_q};
  assign rx_good  = (bcnt == CW'(L)) && !(^sr) && (sr[L-1 -: TAG_W] == rx_tag);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // FSM next state; a mode change restarts from IDLE, and the cycle it is seen in counts as IDLE
  always_comb begin
    nxt = state;
    if (mode_chg)     nxt = updown ? LOAD : IDLE;
    else if (!updown) nxt = IDLE;
    else begin
      case (state)
        IDLE:    nxt = LOAD;
        LOAD:    nxt = SHIFT;
        SHIFT:   if (bcnt == CW'(L - 1)) nxt = GAP;
        GAP:     nxt = (k == ADDR_W'(N - 1)) ? DONE : LOAD;
        DONE:    nxt = DONE;
        default: nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: frame enable low and MSB on the wire only while shifting
  always_comb begin
    sen_drv = 1'b1;
    sd_drv  = 1'b0;
    if (state == SHIFT) begin
      sen_drv = 1'b0;
      sd_drv  = sr[L-1];
    end
  end

  assign sen = updown ? sen_drv : 1'bz;
  assign sd  = updown ? sd_drv  : 1'bz;

  assign bank.bank_a = updown ? k : rx_a;
  assign bank.bank_d = rx_d;
  assign bank.rw     = !rx_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      updown_q <= 1'b0;
      k        <= '0;
      tx_tag   <= '0;
      bcnt     <= '0;
      sr       <= '0;
      good_cnt <= '0;
      rx_tag   <= '0;
      rx_we    <= 1'b0;
      rx_a     <= '0;
      rx_d     <= '0;
      done     <= 1'b0;
      par_err  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      updown_q <= updown;
      par_err  <= 1'b0;
      rx_we    <= 1'b0;
      if (mode_chg) begin
        // Partial frames are dropped silently; err_cnt keeps its history.
        k        <= '0;
        tx_tag   <= '0;
        bcnt     <= '0;
        good_cnt <= '0;
        rx_tag   <= '0;
        done     <= 1'b0;
      end else if (updown) begin
        case (state)
          LOAD: begin
            sr   <= {tx_tag, k, bank.bank_q, tx_par};
            bcnt <= '0;
          end
          SHIFT: begin
            sr   <= sr << 1;
            bcnt <= bcnt + 1'b1;
          end
          GAP: begin
            k      <= k + 1'b1;
            tx_tag <= tx_tag + 1'b1;
            if (k == ADDR_W'(N - 1)) done <= 1'b1;
          end
          default: ;
        endcase
      end else begin
        // rx_we is high during the write cycle, so this lands the cycle after the Nth write.
        if (rx_we && good_cnt == GW'(N)) done <= 1'b1;
        if (!sen) begin
          sr <= {sr[L-2:0], sd};
          if (bcnt != CW'(L + 1)) bcnt <= bcnt + 1'b1;
        end else if (bcnt != '0) begin
          bcnt <= '0;
          if (!done) begin
            if (rx_good) begin
              rx_we    <= 1'b1;
              rx_a     <= sr[L-1-TAG_W -: ADDR_W];
              rx_d     <= sr[DATA_W:1];
              good_cnt <= good_cnt + 1'b1;
              rx_tag   <= rx_tag + 1'b1;
            end else begin
              par_err <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_bank_link.sv
module tb_serial_bank_link;
  logic clk, rst, tx_ud, tx2_ud, tb_sen, tb_sd;
  wire  sen_w, sd_w, sen2, sd2;

  logic       tx_done, tx_perr, rx_done, rx_perr;
  logic [7:0] tx_err, rx_err;
  logic       tx2_done, tx2_perr, rx2_done, rx2_perr;
  logic [7:0] tx2_err, rx2_err;

  serial_bank_link_if #(.DATA_W(18), .ADDR_W(3)) btx ();
  serial_bank_link_if #(.DATA_W(18), .ADDR_W(3)) brx ();
  serial_bank_link_if #(.DATA_W(8),  .ADDR_W(2)) btx2 ();
  serial_bank_link_if #(.DATA_W(8),  .ADDR_W(2)) brx2 ();

  serial_bank_link u_tx (.clk(clk), .rst(rst), .updown(tx_ud), .bank(btx), .done(tx_done),
                         .par_err(tx_perr), .err_cnt(tx_err), .sen(sen_w), .sd(sd_w));
  serial_bank_link u_rx (.clk(clk), .rst(rst), .updown(1'b0), .bank(brx), .done(rx_done),
                         .par_err(rx_perr), .err_cnt(rx_err), .sen(sen_w), .sd(sd_w));
  serial_bank_link #(.DATA_W(8), .ADDR_W(2), .TAG_W(2)) u_tx2 (
    .clk(clk), .rst(rst), .updown(tx2_ud), .bank(btx2), .done(tx2_done),
    .par_err(tx2_perr), .err_cnt(tx2_err), .sen(sen2), .sd(sd2));
  serial_bank_link #(.DATA_W(8), .ADDR_W(2), .TAG_W(2)) u_rx2 (
    .clk(clk), .rst(rst), .updown(1'b0), .bank(brx2), .done(rx2_done),
    .par_err(rx2_perr), .err_cnt(rx2_err), .sen(sen2), .sd(sd2));

  // The bench owns the link whenever the transmitter is not driving it.
  assign sen_w = tx_ud  ? 1'bz : tb_sen;
  assign sd_w  = tx_ud  ? 1'bz : tb_sd;
  assign sen2  = tx2_ud ? 1'bz : 1'b1;
  assign sd2   = tx2_ud ? 1'bz : 1'b0;

  logic [17:0] tx_mem [8];
  logic [17:0] rx_mem [8];
  logic [7:0]  tx2_mem [4];
  logic [7:0]  rx2_mem [4];
  int          rx_wr, rx_perr_n, rx2_wr;

  assign btx.bank_q  = tx_mem[btx.bank_a];
  assign brx.bank_q  = '0;
  assign btx2.bank_q = tx2_mem[btx2.bank_a];
  assign brx2.bank_q = '0;

  always @(negedge clk) begin
    if (brx.rw === 1'b0) begin
      rx_mem[brx.bank_a] = brx.bank_d;
      rx_wr = rx_wr + 1;
    end
    if (rx_perr === 1'b1) rx_perr_n = rx_perr_n + 1;
    if (brx2.rw === 1'b0) begin
      rx2_mem[brx2.bank_a] = brx2.bank_d;
      rx2_wr = rx2_wr + 1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors;
  logic [31:0] cap [8];
  int          capn [8], cap_st [8];
  int          fall_c, done_c, d2c, n2, nf2, f3n;
  logic        p2;
  logic [31:0] s2, f3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] mk(input logic [4:0] t, input logic [2:0] a, input logic [17:0] d);
    mk = {t, a, d, ^{t, a, d}};
  endfunction

  function automatic logic [17:0] dat(input int i);
    dat = 18'h15A00 + 18'(i);
  endfunction

  // Send the top nbits of a 27-bit frame, then hold sen high for gap cycles.
  task automatic send(input logic [26:0] f, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      tb_sen = 1'b0;
      tb_sd  = f[26-i];
    end
    @(negedge clk);
    tb_sen = 1'b1;
    tb_sd  = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  // Cycle 1 is the first edge after updown is raised; captures frames off sen_w/sd_w.
  task automatic run_tx(input int budget, output int fall, output int donec);
    int nf, nb;
    logic prev;
    logic [31:0] sh;
    fall = -1; donec = -1; nf = 0; nb = 0; prev = 1'b1; sh = 0;
    for (int i = 0; i < 8; i++) begin cap[i] = 0; capn[i] = 0; cap_st[i] = 0; end
    for (int c = 1; c <= budget && donec < 0; c++) begin
      @(posedge clk); #1;
      if (sen_w === 1'b0) begin
        if (prev) begin
          if (fall < 0) fall = c;
          if (nf < 8) cap_st[nf] = c;
          sh = 0; nb = 0;
        end
        sh = {sh[30:0], sd_w};
        nb++;
      end else if (!prev) begin
        if (nf < 8) begin cap[nf] = sh; capn[nf] = nb; end
        nf++;
      end
      prev = sen_w;
      if (tx_done === 1'b1) donec = c;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rx_wr = 0; rx_perr_n = 0; rx2_wr = 0;
    rst = 1'b1; tx_ud = 1'b0; tx2_ud = 1'b0; tb_sen = 1'b1; tb_sd = 1'b0;
    for (int i = 0; i < 8; i++) begin tx_mem[i] = 18'h3A5C0 + 18'(i); rx_mem[i] = '0; end
    for (int i = 0; i < 4; i++) begin tx2_mem[i] = 8'hC3 + 8'(i); rx2_mem[i] = '0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_par_err", {31'd0, tx_perr}, 32'd0);
    chk("rst_err_cnt", {24'd0, tx_err}, 32'd0);
    chk("rst_bank_a", {29'd0, brx.bank_a}, 32'd0);
    chk("rst_bank_d", {14'd0, brx.bank_d}, 32'd0);
    chk("rst_rw", {31'd0, brx.rw}, 32'd1);

    // TX of the default bank, looped back into u_rx
    tx_ud = 1'b1;
    run_tx(400, fall_c, done_c);
    chk("tx_first_sen_fall", fall_c, 32'd2);
    chk("tx_done_cycle", done_c, 32'd233);
    chk("tx_frame2_hand", cap[2], 32'h0974B85);
    for (int f = 0; f < 8; f++) begin
      chk($sformatf("tx_frame%0d", f), cap[f], {5'd0, mk(5'(f), 3'(f), 18'h3A5C0 + 18'(f))});
      chk($sformatf("tx_len%0d", f), capn[f], 32'd27);
      chk($sformatf("tx_start%0d", f), cap_st[f], 32'(2 + 29 * f));
    end
    repeat (5) @(negedge clk);
    chk("lb_done", {31'd0, rx_done}, 32'd1);
    chk("lb_err_cnt", {24'd0, rx_err}, 32'd0);
    chk("lb_writes", rx_wr, 32'd8);
    for (int a = 0; a < 8; a++)
      chk($sformatf("lb_mem%0d", a), {14'd0, rx_mem[a]}, 32'h3A5C0 + 32'(a));

    // Mode change at bit 10 of frame 4 (frame 4 starts at cycle 118)
    @(negedge clk); rst = 1'b1; tx_ud = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); tx_ud = 1'b1;
    repeat (128) @(posedge clk);
    #1;
    chk("mc_mid_frame_sen", {31'd0, sen_w}, 32'd0);
    @(negedge clk); tx_ud = 1'b0;
    @(posedge clk); #1;
    chk("mc_done_clear", {31'd0, tx_done}, 32'd0);
    chk("mc_rw", {31'd0, btx.rw}, 32'd1);
    chk("mc_sen_released", {31'd0, sen_w}, 32'd1);
    repeat (3) @(negedge clk);
    tx_ud = 1'b1;
    run_tx(400, fall_c, done_c);
    chk("mc_restart_fall", fall_c, 32'd2);
    chk("mc_restart_frame0", cap[0], {5'd0, mk(5'd0, 3'd0, 18'h3A5C0)});
    chk("mc_restart_done", done_c, 32'd233);

    // RX error handling, bench drives the link
    @(negedge clk); rst = 1'b1; tx_ud = 1'b0; tb_sen = 1'b1; tb_sd = 1'b0;
    @(negedge clk); rst = 1'b0;
    rx_wr = 0; rx_perr_n = 0;
    for (int a = 0; a < 8; a++) rx_mem[a] = '0;
    send(mk(5'd0, 3'd0, dat(0)), 27, 1);
    chk("rx_check_cycle_rw", {31'd0, brx.rw}, 32'd1);
    @(negedge clk);
    chk("rx_write_rw", {31'd0, brx.rw}, 32'd0);
    chk("rx_write_a", {29'd0, brx.bank_a}, 32'd0);
    chk("rx_write_d", {14'd0, brx.bank_d}, {14'd0, dat(0)});
    send(mk(5'd1, 3'd1, dat(1)), 27, 1);
    send(mk(5'd2, 3'd2, dat(2)), 27, 1);
    send(mk(5'd3, 3'd3, dat(3)) ^ 27'h200, 27, 1);
    send(mk(5'd4, 3'd4, dat(4)), 26, 1);
    send(mk(5'd7, 3'd5, dat(5)), 27, 1);
    repeat (3) @(negedge clk);
    chk("rxe_par_err_pulses", rx_perr_n, 32'd3);
    chk("rxe_err_cnt", {24'd0, rx_err}, 32'd3);
    chk("rxe_writes", rx_wr, 32'd3);
    chk("rxe_done_low", {31'd0, rx_done}, 32'd0);
    for (int f = 3; f < 7; f++) send(mk(5'(f), 3'(f), dat(f)), 27, 1);
    repeat (3) @(negedge clk);
    chk("rxe_done_after7", {31'd0, rx_done}, 32'd0);
    send(mk(5'd7, 3'd7, dat(7)), 27, 1);
    repeat (4) @(negedge clk);
    chk("rxe_done", {31'd0, rx_done}, 32'd1);
    chk("rxe_writes8", rx_wr, 32'd8);
    for (int a = 0; a < 8; a++)
      chk($sformatf("rxe_mem%0d", a), {14'd0, rx_mem[a]}, {14'd0, dat(a)});
    send(mk(5'd8, 3'd0, 18'h3FFFF), 27, 1);
    repeat (3) @(negedge clk);
    chk("rxe_ignored_write", rx_wr, 32'd8);
    chk("rxe_ignored_err", {24'd0, rx_err}, 32'd3);

    // Reset in the middle of a frame
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rx_wr = 0; rx_perr_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); tb_sen = 1'b0; tb_sd = 1'(i);
    end
    @(negedge clk); rst = 1'b1; tb_sen = 1'b1; tb_sd = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_writes", rx_wr, 32'd0);
    chk("rstmid_par_err", rx_perr_n, 32'd0);
    chk("rstmid_err_cnt", {24'd0, rx_err}, 32'd0);

    // err_cnt saturation
    for (int i = 0; i < 300; i++) send(mk(5'd0, 3'd0, dat(0)) ^ 27'd1, 27, 1);
    repeat (3) @(negedge clk);
    chk("sat_err_cnt", {24'd0, rx_err}, 32'd255);
    chk("sat_pulses", rx_perr_n, 32'd300);
    chk("sat_writes", rx_wr, 32'd0);
    chk("sat_done", {31'd0, rx_done}, 32'd0);

    // Small-parameter loopback: L = 13, four frames
    @(negedge clk);
    tx2_ud = 1'b1;
    d2c = -1; p2 = 1'b1; nf2 = 0; n2 = 0; s2 = 0; f3 = 0; f3n = 0;
    for (int c = 1; c <= 200 && d2c < 0; c++) begin
      @(posedge clk); #1;
      if (sen2 === 1'b0) begin
        if (p2) begin s2 = 0; n2 = 0; end
        s2 = {s2[30:0], sd2};
        n2++;
      end else if (!p2) begin
        if (nf2 == 3) begin f3 = s2; f3n = n2; end
        nf2++;
      end
      p2 = sen2;
      if (tx2_done === 1'b1) d2c = c;
    end
    chk("p2_done_cycle", d2c, 32'd61);
    chk("p2_frames", nf2, 32'd4);
    chk("p2_frame3", f3, 32'h1F8C);
    chk("p2_frame3_len", f3n, 32'd13);
    repeat (5) @(negedge clk);
    chk("p2_rx_done", {31'd0, rx2_done}, 32'd1);
    chk("p2_rx_err", {24'd0, rx2_err}, 32'd0);
    chk("p2_rx_writes", rx2_wr, 32'd4);
    for (int a = 0; a < 4; a++)
      chk($sformatf("p2_mem%0d", a), {24'd0, rx2_mem[a]}, 32'hC3 + 32'(a));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
